// File: rtl/scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scan_ctrl_pkg
// Shared definitions for the scan shift controller:
//   - state_e           : controller FSM state encoding
//   - CHAIN_LEN_DEFAULT : default number of flops in the driven scan chain
// -----------------------------------------------------------------------------
package scan_ctrl_pkg;

    localparam int CHAIN_LEN_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/scan_shreg.sv
// -----------------------------------------------------------------------------
// scan_shreg
// Shift register with parallel load and serial input, shifting towards bit 0.
// Ports:
//   CLK, RESET_B   : clock, asynchronous active-low reset (clears contents)
//   i_load         : load i_load_data in parallel (has priority over shift)
//   i_load_data    : parallel load value
//   i_shift        : shift right by one, i_ser_in entering at the MSB
//   i_ser_in       : serial input
//   o_q            : current contents (o_q[0] is the serial output)
// -----------------------------------------------------------------------------
module scan_shreg #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET_B,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_shift,
    input  logic         i_ser_in,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
            r_q <= {i_ser_in, r_q[W-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/scan_shift_ctrl.sv
// -----------------------------------------------------------------------------
// scan_shift_ctrl
// Drives one scan chain: shifts a pattern in (LOAD), pulses one functional
// capture (CAPTURE), shifts the chain contents out (UNLOAD) and presents them
// as a result (DONE).
// Ports:
//   CLK, RESET_B          : clock, asynchronous active-low reset
//   PAT_VALID/PAT_READY   : pattern input handshake, PAT_DATA bit 0 goes first
//   PAT_DATA              : pattern to shift into the chain
//   SO                    : serial output of the chain tail flop
//   SCD, SCE, DE          : chain scan data, scan enable, data enable
//   RES_VALID/RES_READY   : result output handshake
//   RES_DATA              : unloaded chain contents, RES_DATA[0] unloaded first
//   BUSY                  : high whenever the FSM is not in IDLE
//   DBG_STATE             : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. PAT_READY is high only in IDLE and RES_VALID only in DONE, so a
// result transfer and a pattern transfer can never share a cycle, and valid
// offered outside those states has no effect.
// -----------------------------------------------------------------------------
module scan_shift_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    input  logic                 PAT_VALID,
    output logic                 PAT_READY,
    input  logic [CHAIN_LEN-1:0] PAT_DATA,
    input  logic                 SO,
    output logic                 SCD,
    output logic                 SCE,
    output logic                 DE,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [CHAIN_LEN-1:0] RES_DATA,
    output logic                 BUSY,
    output state_e               DBG_STATE
);

    localparam int             CW       = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CHAIN_LEN - 1);

    state_e          r_state;
    state_e          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            w_load;
    logic            w_shift;
    logic            w_ser_in;
    logic [CHAIN_LEN-1:0] w_shreg;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_ser_in     = 1'b0;
        PAT_READY    = 1'b0;
        SCE          = 1'b0;
        DE           = 1'b0;
        SCD          = 1'b0;
        RES_VALID    = 1'b0;
        BUSY         = 1'b1;

        unique case (r_state)
            ST_IDLE: begin
                PAT_READY = 1'b1;
                BUSY      = 1'b0;
                if (PAT_VALID) begin
                    w_load       = 1'b1;
                    w_cnt_next   = '0;
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                SCE     = 1'b1;
                DE      = 1'b1;
                SCD     = w_shreg[0];
                w_shift = 1'b1;
                // Counter parks on its last value instead of wrapping; the
                // next state clears it anyway.
                if (r_cnt == CNT_LAST) begin
                    w_next_state = ST_CAPTURE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            ST_CAPTURE: begin
                DE           = 1'b1;
                w_cnt_next   = '0;
                w_next_state = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                SCE      = 1'b1;
                DE       = 1'b1;
                w_shift  = 1'b1;
                w_ser_in = SO;
                if (r_cnt == CNT_LAST) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            ST_DONE: begin
                RES_VALID = 1'b1;
                if (RES_READY) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    scan_shreg #(
        .W (CHAIN_LEN)
    ) u_shreg (
        .CLK         (CLK),
        .RESET_B     (RESET_B),
        .i_load      (w_load),
        .i_load_data (PAT_DATA),
        .i_shift     (w_shift),
        .i_ser_in    (w_ser_in),
        .o_q         (w_shreg)
    );

    assign RES_DATA  = w_shreg;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_scan_shift_ctrl.sv
module tb_scan_shift_ctrl;
    import scan_ctrl_pkg::*;

    localparam int N = 8;

    // ---------------- clock / reset / DUT ----------------
    logic         CLK       = 1'b0;
    logic         RESET_B   = 1'b0;
    logic         PAT_VALID = 1'b0;
    logic [N-1:0] PAT_DATA  = '0;
    logic         RES_READY = 1'b1;
    logic         PAT_READY;
    logic         SO;
    logic         SCD;
    logic         SCE;
    logic         DE;
    logic         RES_VALID;
    logic [N-1:0] RES_DATA;
    logic         BUSY;
    state_e       DBG_STATE;

    always #5 CLK = ~CLK;

    scan_shift_ctrl #(.CHAIN_LEN(N)) dut (
        .CLK       (CLK),
        .RESET_B   (RESET_B),
        .PAT_VALID (PAT_VALID),
        .PAT_READY (PAT_READY),
        .PAT_DATA  (PAT_DATA),
        .SO        (SO),
        .SCD       (SCD),
        .SCE       (SCE),
        .DE        (DE),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES_DATA  (RES_DATA),
        .BUSY      (BUSY),
        .DBG_STATE (DBG_STATE)
    );

    int cycle_cnt = 0;
    always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

    // ---------------- behavioural scan chain ----------------
    // chain[0] is the head (fed by SCD), chain[N-1] the tail (drives SO).
    // A capture cycle either holds the contents or inverts them.
    logic [N-1:0] chain = '0;
    logic         invert_mode = 1'b0;
    always @(posedge CLK) begin
        if (SCE)
            chain <= {chain[N-2:0], SCD};
        else if (DE && invert_mode)
            chain <= ~chain;
    end
    assign SO = chain[N-1];

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_val;
    int           hs_edge     = -1;
    int           valid_rises = 0;
    logic         prev_valid  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle_cnt);
        end
    endtask

    // Monitor samples just before each rising edge, after inputs have settled.
    always begin
        @(negedge CLK);
        #2;
        if (RESET_B && PAT_VALID && PAT_READY)
            hs_edge = cycle_cnt + 1;
        if (RES_VALID && !prev_valid) begin
            valid_rises++;
            if (hs_edge >= 0)
                chk("latency", cycle_cnt - hs_edge, 2 * N + 1);
        end
        if (RES_VALID && RES_READY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h with nothing expected", RES_DATA);
            end else begin
                exp_val = exp_q.pop_front();
                chk("res_data", RES_DATA, exp_val);
            end
        end
        prev_valid = RES_VALID;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic send(input logic [N-1:0] d, input logic [N-1:0] e,
                        input logic keep_valid, output int edge_o);
        int t;
        PAT_DATA  = d;
        PAT_VALID = 1'b1;
        exp_q.push_back(e);
        t = 0;
        while (!PAT_READY && t < 60) begin
            step();
            t++;
        end
        chk("pat_ready_wait", PAT_READY, 1);
        edge_o = cycle_cnt + 1;
        step();
        if (!keep_valid) PAT_VALID = 1'b0;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!RES_VALID && t < 100) begin
            step();
            t++;
        end
        chk("res_valid_wait", RES_VALID, 1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            step();
            t++;
        end
        chk("drain", exp_q.size(), 0);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           e1;
        int           e2;
        int           vr;
        logic [N-1:0] pat;

        // asynchronous reset, before any clock edge
        #2;
        chk("rst_pat_ready", PAT_READY, 1);
        chk("rst_outputs", {SCE, DE, SCD, RES_VALID, BUSY}, 5'b00000);
        chk("rst_state", DBG_STATE, ST_IDLE);
        step();
        step();

        // hold-model chain, handshake on the first edge after reset release
        RESET_B = 1'b1;
        send(8'hA5, 8'hA5, 1'b0, e1);
        wait_drain();

        // capture-invert chain with full control trace
        invert_mode = 1'b1;
        pat = 8'h0F;
        send(pat, 8'hF0, 1'b0, e1);
        for (int i = 0; i < N; i++) begin
            chk("load_trace", {SCE, DE, SCD}, {2'b11, pat[i]});
            step();
        end
        chk("capture_trace", {SCE, DE, SCD}, 3'b010);
        step();
        for (int i = 0; i < N; i++) begin
            chk("unload_trace", {SCE, DE, SCD}, 3'b110);
            step();
        end
        chk("done_valid", {RES_VALID, BUSY}, 2'b11);
        wait_drain();
        invert_mode = 1'b0;

        // result held while the consumer stalls
        RES_READY = 1'b0;
        send(8'h5A, 8'h5A, 1'b0, e1);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            chk("hold", {RES_VALID, SCE, DE, RES_DATA}, {3'b100, 8'h5A});
            step();
        end
        RES_READY = 1'b1;
        step();
        chk("after_ack", {PAT_READY, BUSY, RES_VALID}, 3'b100);
        chk("after_ack_state", DBG_STATE, ST_IDLE);
        step();

        // back-to-back with PAT_VALID held high
        send(8'h01, 8'h01, 1'b1, e1);
        send(8'h80, 8'h80, 1'b0, e2);
        chk("b2b_gap", e2 - e1, 2 * N + 3);
        wait_drain();

        // reset in the middle of LOAD
        send(8'h99, 8'h99, 1'b0, e1);
        repeat (4) @(posedge CLK);
        #1;
        RESET_B = 1'b0;
        exp_q.delete();
        vr = valid_rises;
        #1;
        chk("mid_rst_outputs", {SCE, DE, SCD, RES_VALID, BUSY, PAT_READY}, 6'b000001);
        chk("mid_rst_state", DBG_STATE, ST_IDLE);
        step();
        step();
        RESET_B = 1'b1;
        repeat (30) step();
        chk("no_partial_result", valid_rises, vr);
        send(8'h3C, 8'h3C, 1'b0, e1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
